// File: rtl/ring_inject_arbiter_if.sv
// ring_inject_arbiter_if: handshake bundle between the local requesters, the injection arbiter and the ring node
//   req_valid/req_pkt/req_ready  : requester handshake; requester i owns req_pkt[i*PKT_W +: PKT_W]
//   inj_valid/inj_pkt/inj_accept : offer to the ring node (packetCoreIn / packetSendIn / recievedOut)
//   grant_id/starve/inj_count    : status of the held offer and injection statistics
interface ring_inject_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int PKT_W   = 144
);
   localparam int IW = $clog2(NUM_REQ);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*PKT_W-1:0] req_pkt;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     inj_valid;
   logic [PKT_W-1:0]         inj_pkt;
   logic                     inj_accept;
   logic [IW-1:0]            grant_id;
   logic                     starve;
   logic [31:0]              inj_count;
   modport master (
      output req_valid, req_pkt, inj_accept,
      input  req_ready, inj_valid, inj_pkt, grant_id, starve, inj_count
   );
   modport slave (
      input  req_valid, req_pkt, inj_accept,
      output req_ready, inj_valid, inj_pkt, grant_id, starve, inj_count
   );
endinterface

// File: rtl/ring_inject_arbiter.sv
// ring_inject_arbiter: round-robin scheduler for one ring node's injection port
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of ring_inject_arbiter_if (requester handshake in, ring offer out, status out)
module ring_inject_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int PKT_W        = 144,
   parameter int STARVE_LIMIT = 16
) (
   input logic clk,
   input logic rst,
   ring_inject_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int BW = $clog2(STARVE_LIMIT + 1);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] OFFER = 1'b1;
   localparam logic [IW-1:0] LAST  = IW'(NUM_REQ - 1);
   localparam logic [BW-1:0] LIMIT = BW'(STARVE_LIMIT);
   logic [0:0]       state;
   logic [PKT_W-1:0] pkt;
   logic [IW-1:0]    gid, rr_ptr, w;
   logic [BW-1:0]    blk, blk_nxt;
   logic             starve_q, take, acc;
   logic [31:0]      count;
   // scan from the highest offset down so the nearest valid requester after rr_ptr wins
   always_comb begin
      w = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (bus.req_valid[(int'(rr_ptr) + k) % NUM_REQ]) w = IW'((int'(rr_ptr) + k) % NUM_REQ);
   end
   assign acc  = state == OFFER && bus.inj_accept;
   // the offer register frees up either when empty or when the ring takes it this cycle
   assign take = (state == IDLE || bus.inj_accept) && |bus.req_valid && !rst;
   assign blk_nxt = (state == IDLE || acc) ? '0 : blk == LIMIT ? blk : blk + 1'b1;
   assign bus.req_ready = take ? {{(NUM_REQ-1){1'b0}}, 1'b1} << w : '0;
   assign bus.inj_valid = state == OFFER;
   assign bus.inj_pkt   = pkt;
   assign bus.grant_id  = gid;
   assign bus.starve    = starve_q;
   assign bus.inj_count = count;
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pkt      <= '0;
         gid      <= '0;
         rr_ptr   <= '0;
         blk      <= '0;
         starve_q <= 1'b0;
         count    <= '0;
      end else begin
         if (take) begin
            state  <= OFFER;
            pkt    <= bus.req_pkt[int'(w) * PKT_W +: PKT_W];
            gid    <= w;
            rr_ptr <= w == LAST ? '0 : w + 1'b1;
         end else if (acc) begin
            state <= IDLE;
         end
         if (acc) count <= count + 1'b1;
         blk      <= blk_nxt;
         starve_q <= blk_nxt >= LIMIT;
      end
   end
endmodule

// File: tb/tb_ring_inject_arbiter.sv
// tb_ring_inject_arbiter: vector table, corner sequences and randomized model check of ring_inject_arbiter
module tb_ring_inject_arbiter;
   localparam int N = 4, PW = 144, LIM = 16;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   ring_inject_arbiter_if #(.NUM_REQ(N), .PKT_W(PW)) bus();
   ring_inject_arbiter #(.NUM_REQ(N), .PKT_W(PW), .STARVE_LIMIT(LIM)) dut (.clk(clk), .rst(rst), .bus(bus));
   int passed = 0, total = 0;
   logic [PW-1:0] pk [N];
   typedef struct {
      logic [N-1:0] rv;
      logic         acc;
      logic [N-1:0] ready;
      logic         valid;
      logic [1:0]   gid;
      logic [31:0]  cnt;
   } vec_t;
   vec_t tbl [16];
   // reference model: one optional held packet, a rotating pointer and a blocked-cycle tally
   bit            m_held, m_starve;
   int            m_id, m_ptr, m_blk, mode;
   logic [PW-1:0] m_pkt;
   logic [31:0]   m_cnt;
   logic [N-1:0]  pend, exp_ready;
   logic          a;
   task automatic chk(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic drive(logic [N-1:0] rv, logic acc);
      bus.req_valid  = rv;
      bus.inj_accept = acc;
      for (int i = 0; i < N; i++) bus.req_pkt[i*PW +: PW] = pk[i];
   endtask
   task automatic do_reset();
      rst = 1'b1;
      drive('0, 1'b0);
      tick();
      rst = 1'b0;
   endtask
   task automatic outs(string n, logic v, logic [1:0] g, logic s, logic [31:0] c);
      chk({n, "_valid"}, PW'(bus.inj_valid), PW'(v));
      chk({n, "_gid"}, PW'(bus.grant_id), PW'(g));
      chk({n, "_starve"}, PW'(bus.starve), PW'(s));
      chk({n, "_count"}, PW'(bus.inj_count), PW'(c));
   endtask
   function automatic logic [PW-1:0] rand_pkt();
      logic [159:0] r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return r[PW-1:0];
   endfunction
   function automatic int winner(logic [N-1:0] v);
      for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction
   initial begin
      for (int i = 0; i < N; i++) pk[i] = rand_pkt();
      drive('1, 1'b1);
      tick();
      #1 chk("rst_ready", PW'(bus.req_ready), '0);
      tick();
      outs("rst", 1'b0, 2'd0, 1'b0, 32'd0);
      chk("rst_pkt", bus.inj_pkt, '0);
      rst = 1'b0;
      // single requester, ring accepting
      pk[0] = {8'd0, 8'd2, 128'h1234};
      drive(4'b0001, 1'b1);
      #1 chk("t1_ready", PW'(bus.req_ready), PW'(4'b0001));
      tick();
      outs("t1_offer", 1'b1, 2'd0, 1'b0, 32'd0);
      chk("t1_dest", PW'(bus.inj_pkt[135:128]), PW'(8'd2));
      chk("t1_data", PW'(bus.inj_pkt[127:0]), PW'(128'h1234));
      drive(4'b0000, 1'b1);
      tick();
      outs("t1_done", 1'b0, 2'd0, 1'b0, 32'd1);
      // vector table from a fresh reset: rotation, pointer skipping, blocking
      tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd0};
      tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd1};
      tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'd2};
      tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'd3};
      tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd4};
      tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd5};
      tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 32'd6};
      tbl[7]  = '{4'b0011, 1'b0, 4'b0001, 1'b1, 2'd0, 32'd6};
      tbl[8]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd7};
      tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 32'd7};
      tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 32'd8};
      tbl[11] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 32'd8};
      tbl[12] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd3, 32'd8};
      tbl[13] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'd9};
      tbl[14] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd10};
      tbl[15] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'd11};
      for (int i = 0; i < N; i++) pk[i] = {8'(i), 8'(i + 1), {4{32'hA5A50000 + 32'(i)}}};
      do_reset();
      for (int r = 0; r < 16; r++) begin
         drive(tbl[r].rv, tbl[r].acc);
         #1 chk($sformatf("tbl%0d_ready", r), PW'(bus.req_ready), PW'(tbl[r].ready));
         tick();
         outs($sformatf("tbl%0d", r), tbl[r].valid, tbl[r].gid, 1'b0, tbl[r].cnt);
         if (tbl[r].valid) chk($sformatf("tbl%0d_pkt", r), bus.inj_pkt, pk[tbl[r].gid]);
      end
      // starvation: one offer blocked for 20 cycles, then accepted
      do_reset();
      pk[0] = rand_pkt();
      drive(4'b0001, 1'b0);
      tick();
      drive(4'b0000, 1'b0);
      for (int c = 1; c <= 20; c++) begin
         tick();
         chk($sformatf("starve_c%0d", c), PW'(bus.starve), PW'(c >= LIM));
         chk($sformatf("starve_pkt%0d", c), bus.inj_pkt, pk[0]);
      end
      drive(4'b0000, 1'b1);
      tick();
      outs("starve_end", 1'b0, 2'd0, 1'b0, 32'd1);
      // reset in the middle of a starved offer
      drive(4'b0010, 1'b0);
      tick();
      drive(4'b0000, 1'b0);
      for (int c = 0; c < 17; c++) tick();
      outs("pre_rst", 1'b1, 2'd1, 1'b1, 32'd1);
      rst = 1'b1;
      drive(4'b0001, 1'b1);
      #1 chk("mid_rst_ready", PW'(bus.req_ready), '0);
      tick();
      outs("mid_rst", 1'b0, 2'd0, 1'b0, 32'd0);
      rst = 1'b0;
      drive(4'b0000, 1'b1);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("no_replay%0d", c), PW'(bus.inj_valid), '0);
      end
      // counter wrap from all-ones
      do_reset();
      drive(4'b0001, 1'b0);
      tick();
      drive(4'b0000, 1'b0);
      force dut.count = 32'hFFFF_FFFF;
      #1 release dut.count;
      #1 chk("wrap_pre", PW'(bus.inj_count), PW'(32'hFFFF_FFFF));
      @(negedge clk);
      drive(4'b0000, 1'b1);
      tick();
      chk("wrap", PW'(bus.inj_count), '0);
      // randomized traffic against the reference model
      do_reset();
      m_held = 0; m_starve = 0; m_id = 0; m_ptr = 0; m_blk = 0; m_pkt = '0; m_cnt = '0;
      pend = '0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 64 == 0) mode = $urandom_range(0, 2);
         for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               pk[i] = rand_pkt();
            end
         rst = $urandom_range(0, 399) == 0;
         a = mode == 0 ? $urandom_range(0, 39) == 0 : mode == 1 ? 1'($urandom_range(0, 1)) : $urandom_range(0, 7) != 0;
         drive(pend, a);
         exp_ready = (!rst && (!m_held || a) && winner(pend) >= 0) ? 4'b0001 << winner(pend) : 4'b0000;
         #1 chk("rnd_ready", PW'(bus.req_ready), PW'(exp_ready));
         @(posedge clk);
         if (rst) begin
            m_held = 0; m_starve = 0; m_id = 0; m_ptr = 0; m_blk = 0; m_pkt = '0; m_cnt = '0;
         end else begin
            m_blk = (m_held && !a) ? (m_blk < LIM ? m_blk + 1 : LIM) : 0;
            m_starve = m_blk >= LIM;
            if (m_held && a) begin
               m_cnt = m_cnt + 1;
               m_held = 0;
            end
            if (exp_ready != 0) begin
               m_id = winner(pend);
               m_held = 1;
               m_pkt = pk[m_id];
               m_ptr = (m_id + 1) % N;
            end
         end
         pend = pend & ~exp_ready;
         @(negedge clk);
         chk("rnd_valid", PW'(bus.inj_valid), PW'(m_held));
         chk("rnd_pkt", bus.inj_pkt, m_pkt);
         chk("rnd_gid", PW'(bus.grant_id), PW'(m_id));
         chk("rnd_starve", PW'(bus.starve), PW'(m_starve));
         chk("rnd_count", PW'(bus.inj_count), PW'(m_cnt));
      end
      rst = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
